// File: rtl/packet_filter_pkg.sv
// rtl/packet_filter_pkg.sv - shared types and register map for the egress scheduler
package packet_filter_pkg;

   typedef enum logic {IDLE, XFER} sched_state_t;

   localparam logic [7:0] WRR_WEIGHT_BASE = 8'h00;
   localparam logic [7:0] WRR_CTRL        = 8'h10;
   localparam logic [7:0] WRR_CNT_LO      = 8'h11;
   localparam logic [7:0] WRR_CNT_HI      = 8'h12;

   localparam int WRR_WEIGHT_RESET = 1;

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - rotating find-first-set starting at a pointer
module rr_priority_pick #(
   parameter int N_PORTS   = 4,
   parameter int IDX_WIDTH = $clog2(N_PORTS)
) (
   input  logic [N_PORTS-1:0]   req,
   input  logic [IDX_WIDTH-1:0] ptr,
   output logic                 found,
   output logic [IDX_WIDTH-1:0] index
);

   logic [IDX_WIDTH:0] pos;

   // Scan from farthest to nearest so the nearest set bit after ptr wins.
   always_comb begin
      found = 1'b0;
      index = '0;
      pos   = '0;
      for (int k = N_PORTS - 1; k >= 0; k--) begin
         pos = {1'b0, ptr} + (IDX_WIDTH + 1)'(k);
         if (pos >= (IDX_WIDTH + 1)'(N_PORTS))
            pos = pos - (IDX_WIDTH + 1)'(N_PORTS);
         if (req[pos[IDX_WIDTH-1:0]]) begin
            found = 1'b1;
            index = pos[IDX_WIDTH-1:0];
         end
      end
   end

endmodule

// File: rtl/wrr_packet_scheduler.sv
// rtl/wrr_packet_scheduler.sv - packet-granular weighted round-robin egress scheduler
module wrr_packet_scheduler
   import packet_filter_pkg::*;
#(
   parameter int N_PORTS      = 4,
   parameter int IDX_WIDTH    = $clog2(N_PORTS),
   parameter int WEIGHT_WIDTH = 4
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [7:0]                     writedata,
   input  logic                           write,
   input  logic                           chipselect,
   input  logic [7:0]                     address,
   input  logic                           read,
   output logic [7:0]                     readdata,
   input  logic [IDX_WIDTH-1:0]           egress_port_id,
   input  logic [N_PORTS-1:0]             ingress_valid,
   input  logic [N_PORTS-1:0]             ingress_last,
   input  logic [N_PORTS*IDX_WIDTH-1:0]   ingress_dst,
   input  logic                           egress_ready,
   output logic [IDX_WIDTH-1:0]           selected_ingress,
   output logic [N_PORTS-1:0]             grant,
   output logic                           egress_valid,
   output logic                           egress_last,
   output logic [N_PORTS-1:0]             ingress_ready
);

   sched_state_t            state;
   logic [IDX_WIDTH-1:0]    sel;
   logic [IDX_WIDTH-1:0]    sel_next;
   logic [IDX_WIDTH-1:0]    rr_ptr;
   logic [WEIGHT_WIDTH-1:0] credit;
   logic [WEIGHT_WIDTH-1:0] weight [N_PORTS];
   logic                    enable;
   logic [15:0]             pkt_count;
   logic [7:0]              cnt_shadow;
   logic [N_PORTS-1:0]      eligible;
   logic                    pick_found;
   logic [IDX_WIDTH-1:0]    pick_idx;
   logic                    pkt_end;
   logic                    reg_wr;
   logic                    reg_rd;
   logic [7:0]              weight_ofs;
   logic                    weight_hit;
   logic [7:0]              rd_data;

   always_comb begin
      eligible = '0;
      for (int i = 0; i < N_PORTS; i++)
         eligible[i] = ingress_valid[i] & enable & (weight[i] != '0) &
                       (ingress_dst[i*IDX_WIDTH +: IDX_WIDTH] == egress_port_id);
   end

   rr_priority_pick #(
      .N_PORTS   (N_PORTS),
      .IDX_WIDTH (IDX_WIDTH)
   ) u_pick (
      .req   (eligible),
      .ptr   (rr_ptr),
      .found (pick_found),
      .index (pick_idx)
   );

   assign pkt_end    = (state == XFER) & ingress_valid[sel] & egress_ready & ingress_last[sel];
   assign sel_next   = (sel == IDX_WIDTH'(N_PORTS - 1)) ? '0 : sel + 1'b1;
   assign reg_wr     = chipselect & write;
   assign reg_rd     = chipselect & read;
   assign weight_ofs = address - WRR_WEIGHT_BASE;
   assign weight_hit = weight_ofs < 8'(N_PORTS);

   // Handshake is a straight passthrough of the owner; grant already holds one-hot(sel).
   assign selected_ingress = sel;
   assign egress_valid     = (state == XFER) & ingress_valid[sel];
   assign egress_last      = (state == XFER) & ingress_last[sel];
   assign ingress_ready    = ((state == XFER) && egress_ready) ? grant : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         sel    <= '0;
         grant  <= '0;
         rr_ptr <= '0;
         credit <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  sel   <= pick_idx;
                  grant <= N_PORTS'(1) << pick_idx;
                  state <= XFER;
                  // Remaining credit on the pointer ingress lets it keep its turn.
                  if (!(pick_idx == rr_ptr && credit != '0)) begin
                     credit <= weight[pick_idx];
                     rr_ptr <= pick_idx;
                  end
               end
            end
            XFER: begin
               if (pkt_end) begin
                  state <= IDLE;
                  grant <= '0;
                  if (credit == WEIGHT_WIDTH'(1)) begin
                     credit <= '0;
                     rr_ptr <= sel_next;
                  end else if (credit != '0) begin
                     credit <= credit - 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      rd_data = '0;
      if (weight_hit) begin
         rd_data = 8'(weight[weight_ofs[IDX_WIDTH-1:0]]);
      end else begin
         case (address)
            WRR_CTRL:   rd_data = {7'd0, enable};
            WRR_CNT_LO: rd_data = pkt_count[7:0];
            WRR_CNT_HI: rd_data = cnt_shadow;
            default:    rd_data = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N_PORTS; i++)
            weight[i] <= WEIGHT_WIDTH'(WRR_WEIGHT_RESET);
         enable     <= 1'b1;
         pkt_count  <= '0;
         cnt_shadow <= '0;
         readdata   <= '0;
      end else begin
         if (reg_wr && weight_hit)
            weight[weight_ofs[IDX_WIDTH-1:0]] <= writedata[WEIGHT_WIDTH-1:0];
         if (reg_wr && address == WRR_CTRL)
            enable <= writedata[0];
         // A clear in the same cycle as a packet end must win.
         if (reg_wr && address == WRR_CNT_LO)
            pkt_count <= '0;
         else if (pkt_end && pkt_count != 16'hFFFF)
            pkt_count <= pkt_count + 16'd1;
         if (reg_rd) begin
            readdata <= rd_data;
            if (address == WRR_CNT_LO)
               cnt_shadow <= pkt_count[15:8];
         end
      end
   end

endmodule

// File: tb/tb_wrr_packet_scheduler.sv
// tb/tb_wrr_packet_scheduler.sv - directed self-checking bench for wrr_packet_scheduler
module tb_wrr_packet_scheduler;

   localparam int N  = 4;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [7:0]    writedata;
   logic          write;
   logic          chipselect;
   logic [7:0]    address;
   logic          read;
   logic [7:0]    readdata;
   logic [IW-1:0] egress_port_id;
   logic [N-1:0]  ingress_valid;
   logic [N-1:0]  ingress_last;
   logic [N*IW-1:0] ingress_dst;
   logic          egress_ready;
   logic [IW-1:0] selected_ingress;
   logic [N-1:0]  grant;
   logic          egress_valid;
   logic          egress_last;
   logic [N-1:0]  ingress_ready;

   int compared   = 0;
   int mismatched = 0;
   int src_len  [N];
   int src_pkts [N];
   int src_beat [N];
   int order[$];
   int beats[$];
   int exp_q[$];
   logic [7:0] rd;

   always #5 clk = ~clk;

   wrr_packet_scheduler dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .writedata        (writedata),
      .write            (write),
      .chipselect       (chipselect),
      .address          (address),
      .read             (read),
      .readdata         (readdata),
      .egress_port_id   (egress_port_id),
      .ingress_valid    (ingress_valid),
      .ingress_last     (ingress_last),
      .ingress_dst      (ingress_dst),
      .egress_ready     (egress_ready),
      .selected_ingress (selected_ingress),
      .grant            (grant),
      .egress_valid     (egress_valid),
      .egress_last      (egress_last),
      .ingress_ready    (ingress_ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_src();
      for (int i = 0; i < N; i++) begin
         ingress_valid[i] = (src_pkts[i] > 0);
         ingress_last[i]  = (src_beat[i] == src_len[i] - 1);
      end
   endtask

   task automatic clear_src();
      for (int i = 0; i < N; i++) begin
         src_len[i]  = 1;
         src_pkts[i] = 0;
         src_beat[i] = 0;
      end
      drive_src();
   endtask

   task automatic start_src(input int i, input int len, input int pkts);
      src_len[i]  = len;
      src_pkts[i] = pkts;
      src_beat[i] = 0;
      drive_src();
   endtask

   // One clock: record handshakes that the coming edge accepts, then advance the sources.
   task automatic tick();
      logic [N-1:0] fire;
      logic [N-1:0] lst;
      #1;
      fire = ingress_valid & ingress_ready;
      lst  = ingress_last;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (fire[i]) begin
            beats.push_back(i);
            if (lst[i]) begin
               order.push_back(i);
               src_beat[i] = 0;
               src_pkts[i]--;
            end else begin
               src_beat[i]++;
            end
         end
      end
      drive_src();
      @(negedge clk);
   endtask

   task automatic reg_write(input logic [7:0] a, input logic [7:0] d);
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      tick();
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic reg_read(input logic [7:0] a, output logic [7:0] d);
      chipselect = 1'b1; read = 1'b1; address = a;
      tick();
      chipselect = 1'b0; read = 1'b0;
      d = readdata;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      egress_ready = 1'b1;
      clear_src();
      tick();
      tick();
      reset_n = 1'b1;
      order.delete();
      beats.delete();
   endtask

   task automatic run_until(input string tag, input int n, input int bound);
      int t;
      t = 0;
      while (order.size() < n && t < bound) begin
         tick();
         t++;
      end
      chk({tag, "_pkts_done"}, order.size(), n);
   endtask

   task automatic check_seq(input string tag, input int got[$], input int exp[$]);
      chk({tag, "_len"}, got.size(), exp.size());
      for (int k = 0; k < exp.size(); k++)
         chk($sformatf("%s[%0d]", tag, k), (k < got.size()) ? got[k] : -1, exp[k]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      writedata = '0; write = 1'b0; chipselect = 1'b0; address = '0; read = 1'b0;
      egress_port_id = 2'd1;
      egress_ready = 1'b1;
      ingress_dst = {2'd1, 2'd1, 2'd1, 2'd0};
      clear_src();
      // Ingress 0 is valid but addressed to another egress; only ingress 2 may win.
      start_src(0, 2, 1);
      start_src(2, 2, 1);
      @(negedge clk);
      tick();
      tick();
      chk("rst_grant", grant, 4'b0000);
      chk("rst_sel", selected_ingress, 2'd0);
      chk("rst_evalid", egress_valid, 1'b0);
      chk("rst_elast", egress_last, 1'b0);
      chk("rst_iready", ingress_ready, 4'b0000);
      chk("rst_readdata", readdata, 8'h00);

      reset_n = 1'b1;
      #1;
      chk("t1_grant_cycle1", grant, 4'b0000);
      tick();
      chk("t1_grant_cycle2", grant, 4'b0100);
      chk("t1_sel", selected_ingress, 2'd2);
      chk("t1_evalid", egress_valid, 1'b1);
      chk("t1_elast_b0", egress_last, 1'b0);
      chk("t1_iready", ingress_ready, 4'b0100);
      egress_ready = 1'b0;
      #1;
      chk("t1_iready_follow", ingress_ready, 4'b0000);
      egress_ready = 1'b1;
      tick();
      chk("t1_elast_b1", egress_last, 1'b1);
      tick();
      chk("t1_idle_grant", grant, 4'b0000);
      chk("t1_idle_evalid", egress_valid, 1'b0);
      exp_q = '{2};
      check_seq("t1_order", order, exp_q);

      ingress_dst = {2'd1, 2'd1, 2'd1, 2'd1};
      do_reset();
      start_src(0, 2, 2);
      start_src(3, 2, 2);
      run_until("t2", 4, 60);
      exp_q = '{0, 3, 0, 3};
      check_seq("t2_order", order, exp_q);
      exp_q = '{0, 0, 3, 3, 0, 0, 3, 3};
      check_seq("t2_beats", beats, exp_q);

      do_reset();
      reg_write(8'h00, 8'h03);
      start_src(0, 2, 6);
      start_src(3, 2, 2);
      run_until("t3", 8, 150);
      exp_q = '{0, 0, 0, 3, 0, 0, 0, 3};
      check_seq("t3_order", order, exp_q);
      reg_read(8'h11, rd);
      chk("t3_cnt_lo", rd, 8'h08);
      reg_read(8'h12, rd);
      chk("t3_cnt_hi", rd, 8'h00);
      reg_read(8'h00, rd);
      chk("t3_weight0", rd, 8'h03);
      tick();
      chk("t3_readdata_hold", readdata, 8'h03);
      reg_read(8'h03, rd);
      chk("t3_weight3", rd, 8'h01);
      reg_read(8'h10, rd);
      chk("t3_ctrl", rd, 8'h01);
      reg_read(8'h20, rd);
      chk("t3_unmapped", rd, 8'h00);
      reg_write(8'h11, 8'h00);
      reg_read(8'h11, rd);
      chk("t3_cnt_cleared", rd, 8'h00);

      do_reset();
      start_src(1, 3, 1);
      tick();
      chk("t4_grant1", grant, 4'b0010);
      tick();
      egress_ready = 1'b0;
      start_src(2, 1, 1);
      for (int c = 0; c < 5; c++) begin
         tick();
         chk($sformatf("t4_stall_grant%0d", c), grant, 4'b0010);
         chk($sformatf("t4_stall_iready%0d", c), ingress_ready, 4'b0000);
      end
      egress_ready = 1'b1;
      tick();
      chk("t4_elast", egress_last, 1'b1);
      tick();
      chk("t4_idle_grant", grant, 4'b0000);
      tick();
      chk("t4_grant2", grant, 4'b0100);
      run_until("t4", 2, 10);
      exp_q = '{1, 2};
      check_seq("t4_order", order, exp_q);

      do_reset();
      start_src(1, 3, 3);
      tick();
      tick();
      reg_write(8'h01, 8'h00);
      start_src(0, 2, 2);
      run_until("t5", 3, 60);
      repeat (8) tick();
      exp_q = '{1, 0, 0};
      check_seq("t5_order", order, exp_q);
      chk("t5_w0_grant", grant, 4'b0000);
      chk("t5_w0_evalid", egress_valid, 1'b0);
      reg_write(8'h10, 8'h00);
      start_src(0, 2, 1);
      repeat (8) tick();
      chk("t5_dis_grant", grant, 4'b0000);
      chk("t5_dis_evalid", egress_valid, 1'b0);
      chk("t5_dis_pkts", order.size(), 3);
      reg_read(8'h10, rd);
      chk("t5_ctrl", rd, 8'h00);

      src_pkts[0] = 0;
      src_pkts[1] = 0;
      drive_src();
      reg_write(8'h10, 8'h01);
      start_src(2, 4, 1);
      tick();
      chk("t6_grant", grant, 4'b0100);
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6_arst_grant", grant, 4'b0000);
      chk("t6_arst_sel", selected_ingress, 2'd0);
      chk("t6_arst_evalid", egress_valid, 1'b0);
      chk("t6_arst_iready", ingress_ready, 4'b0000);
      clear_src();
      tick();
      reset_n = 1'b1;
      reg_read(8'h01, rd);
      chk("t6_weight1", rd, 8'h01);
      reg_read(8'h10, rd);
      chk("t6_ctrl", rd, 8'h01);
      order.delete();
      start_src(1, 1, 1);
      start_src(3, 1, 1);
      run_until("t6", 2, 20);
      exp_q = '{1, 3};
      check_seq("t6_order", order, exp_q);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/wrr_packet_scheduler.md
Name: wrr_packet_scheduler

Overview:
- Packet-granular weighted round-robin scheduler for one egress port of the packet switch. It is a drop-in upgrade of the per-egress plain round-robin arbiter.
- Selects among N_PORTS AXIS ingress requesters whose tdest matches this egress. Each grant is held for a whole packet.
- Each ingress may send up to WEIGHT[i] consecutive packets before the pointer advances.
- Weights, enable and a packet counter are exposed on an 8-bit Avalon-MM slave.

Parameters:
- N_PORTS, 4, number of ingress requesters (2..8).
- IDX_WIDTH, $clog2(N_PORTS), width of dest/select indices.
- WEIGHT_WIDTH, 4, width of per-ingress weight and credit counter.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- writedata  in  8  Avalon-MM write data.
- write  in  1  Avalon-MM write strobe.
- chipselect  in  1  Avalon-MM select.
- address  in  8  Avalon-MM register address.
- read  in  1  Avalon-MM read strobe.
- readdata  out  8  registered read data.
- egress_port_id  in  IDX_WIDTH  static ID of this egress.
- ingress_valid  in  N_PORTS  per-ingress tvalid.
- ingress_last  in  N_PORTS  per-ingress tlast.
- ingress_dst  in  N_PORTS*IDX_WIDTH  per-ingress tdest, flattened; ingress i occupies bits [i*IDX_WIDTH +: IDX_WIDTH].
- egress_ready  in  1  downstream tready.
- selected_ingress  out  IDX_WIDTH  mux select for the datapath.
- grant  out  N_PORTS  one-hot current owner.
- egress_valid  out  1  egress tvalid.
- egress_last  out  1  egress tlast.
- ingress_ready  out  N_PORTS  per-ingress tready.

Behaviour:
- Reset values (reset_n low, asynchronous):
  - readdata=0, selected_ingress=0, grant=0, egress_valid=0, egress_last=0, ingress_ready=0.
  - state=IDLE, rr_ptr=0, credit=0, pkt_count=0.
  - All weights=1; enable=1.
- Eligibility: eligible[i] = ingress_valid[i] & (ingress_dst[i]==egress_port_id) & (weight[i]!=0) & enable.
- State IDLE:
  - If any eligible bit is set, pick the first eligible index scanning rr_ptr, rr_ptr+1, ... modulo N_PORTS.
  - Register sel and grant, then go to XFER.
  - If the winner equals rr_ptr and credit!=0, credit is kept; otherwise credit loads weight[winner] and rr_ptr moves to the winner.
  - Arbitration latency is 1 cycle; the first beat can transfer in the cycle after the request is seen.
  - In IDLE all handshake outputs are 0.
- State XFER (combinational passthrough of the handshake):
  - egress_valid = ingress_valid[sel].
  - egress_last = ingress_last[sel].
  - ingress_ready[sel] = egress_ready; ingress_ready is 0 for every other index.
  - selected_ingress = sel; grant = one-hot(sel).
- End of packet: a beat with ingress_valid[sel] & egress_ready & ingress_last[sel].
  - Saturating-increment pkt_count; return to IDLE.
  - If credit==1: credit=0 and rr_ptr=sel+1 (wrap at N_PORTS).
  - Otherwise: credit decrements and rr_ptr stays at sel.
- The grant is never revoked mid-packet. This holds through:
  - gaps where ingress_valid[sel]=0,
  - weight writes,
  - clearing enable; new grants are blocked only from the next IDLE.
- A weight write takes effect at the next credit load.
- Writing weight=0 for an ingress removes it from arbitration immediately in IDLE.
- Simultaneous register write and packet end: both take effect; the counter clear wins over the increment.
- pkt_count saturates at 0xFFFF.
- Registers, 8-bit, active on chipselect:
  - 0x00..N_PORTS-1: weight[i], in writedata[WEIGHT_WIDTH-1:0]; read back zero-extended.
  - 0x10: control; bit0 = enable.
  - 0x11: pkt_count[7:0]. Reading it snapshots pkt_count[15:8] into a shadow register; any write clears the counter.
  - 0x12: shadow high byte.
  - Unmapped addresses read as 0x00.
  - readdata updates one cycle after the read strobe and holds otherwise.
- Reset mid-packet returns to IDLE with all outputs 0. The upstream partial packet is the caller's responsibility.

Decomposition:
- Shared package packet_filter_pkg:
  - sched_state_t enum {IDLE, XFER};
  - register address constants WRR_WEIGHT_BASE=8'h00, WRR_CTRL=8'h10, WRR_CNT_LO=8'h11, WRR_CNT_HI=8'h12;
  - WRR_WEIGHT_RESET=1.
- One sub-module: rr_priority_pick (N_PORTS). Combinational rotate / find-first-set from a pointer; outputs found and index.

Test Plan:
- Reset with ingress 2 valid to egress 1 on egress_port_id=1 -> all outputs 0 during reset. After release: grant=4'b0100 on the 2nd cycle, ingress_ready[2] follows egress_ready, egress_last tracks tlast.
- Ingresses 0 and 3 continuously send 2-beat packets to this egress, weights 1/1 -> packet order 0,3,0,3; no beat from 3 appears between the two beats of a 0 packet.
- Weights w0=3, w3=1, both continuously requesting -> order 0,0,0,3,0,0,0,3; pkt_count reads 8 (0x11=0x08, 0x12=0x00).
- egress_ready=0 for 5 cycles mid-packet from ingress 1, and ingress 2 requests meanwhile -> grant stays 4'b0010, no ingress_ready asserted; ingress 2 is granted 1 cycle after ingress 1's last beat.
- Write weight[1]=0 while ingress 1 is mid-packet -> the current packet completes; ingress 1 is never granted again while ingress 0 is served. Write control=0 -> no new grants; egress_valid=0 in IDLE.
- reset_n low mid-packet -> outputs 0 asynchronously; after release rr_ptr=0 and weights=1.
